key_bounce_gen: RTL and testbench
=================================

// Module: key_bounce_gen
// PURPOSE
//  Synthesizable bouncing-pushbutton source: the transmit end of the key_filter input path.
//  On a start pulse it emits one full press/hold/release waveform on key_out.
//  Contact bounce on each edge is pseudo-random but reproducible from SEED.
//  Used for on-board self-test and loopback benches that drive key_filter without a physical key.
//  key_out is active-low (idle high, pressed low), matching the key_in convention of key_filter.
// PARAMETERS
//  BOUNCE_PAIRS  4       glitch pairs added after the first edge of each press/release; 0 = clean edges
//  SEG_MIN       16      minimum length of one bounce segment, in clk cycles (>=1)
//  SEG_BITS      6       segment length = SEG_MIN + lfsr[SEG_BITS-1:0]
//  HOLD_W        24      width of hold_cycles
//  SEED          16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        1-cycle request; accepted only when busy=0
//  hold_cycles  in   HOLD_W   stable-low time between press and release; sampled on accept
//  busy         out  1        high from the cycle after accept until done
//  done         out  1        1-cycle pulse when the waveform has finished
//  key_out      out  1        generated key level; 1 = released
// BEHAVIOUR
//  Reset values: key_out=1, busy=0, done=0, state=IDLE, lfsr=SEED, counters=0.
//  Reset asserted mid-waveform: outputs return to reset values immediately; no done pulse.
//  States:
//   - IDLE: start=1 latches hold (0 treated as 1) and moves to PRESS.
//     Cycle t+1 after accept: key_out=0, busy=1.
//   - PRESS: after the first edge, 2*BOUNCE_PAIRS further toggles; key_out ends low.
//     After the final toggle, go to HOLD; the final segment time is not waited out.
//   - HOLD: key_out stays low for hold cycles (counted from the final press edge inclusive).
//     Then go to RELEASE.
//   - RELEASE: first edge takes key_out to 1, then 2*BOUNCE_PAIRS toggles; key_out ends high.
//     Then go to DONE.
//   - DONE: one cycle with done=1 and busy=0; next cycle IDLE.
//  Segment timing: at every edge, seg_cnt loads SEG_MIN + lfsr[SEG_BITS-1:0].
//   - The next toggle occurs when seg_cnt expires.
//   - Time between toggles is exactly the loaded value, in cycles.
//  LFSR: 16-bit Galois, mask 16'hB400. Steps once per edge, never per cycle.
//   - Waveform is fully determined by SEED and the start history.
//  Counters sized to hold max(SEG_MIN + 2^SEG_BITS - 1, hold) without wrap. Unsigned arithmetic only.
//  start while busy, or in the DONE cycle: ignored, no queuing.
//  start in the same cycle rst is released: ignored.
//  Edge count per waveform: exactly 2*(2*BOUNCE_PAIRS+1) transitions of key_out.
// STRUCTURE
//  Shared package key_sim_pkg:
//   - state encoding (IDLE, PRESS, HOLD, RELEASE, DONE)
//   - LFSR mask 16'hB400
//   - KEY_PRESSED=1'b0 / KEY_RELEASED=1'b1
//  One sub-module: lfsr16 (clk, rst, step, seed param, q[15:0]), reused by other test sources.
//  The top holds the FSM, seg_cnt, hold_cnt and edge counter.
// TESTING
//  1. BOUNCE_PAIRS=0, start at t, hold_cycles=10:
//     key_out=0 over t+1..t+10, 1 at t+11, done=1 at t+12, busy=1 over t+1..t+11.
//  2. hold_cycles=0, BOUNCE_PAIRS=0: behaves as hold=1.
//     key_out low exactly one cycle; done at t+3.
//  3. Defaults, SEED=16'hACE1:
//     - exactly 18 key_out transitions;
//     - every inter-toggle gap in 16..79;
//     - gap sequence matches a reference LFSR model;
//     - the final low level lasts hold_cycles.
//  4. start pulsed during HOLD and during DONE:
//     no effect on key_out, single done; a new start in the cycle after done is accepted.
//  5. rst pulsed mid-PRESS:
//     key_out=1 and busy=0 asynchronously; no done; next start replays the SEED sequence.
//  6. Loopback into key_filter (SEG_MIN + 63 below the filter window, hold much longer than the window):
//     exactly one press key_flag and one release key_flag per start.

Source files
------------

// File: rtl/key_sim_pkg.sv
// Shared definitions for synthesizable key/contact stimulus sources:
// FSM state encoding, LFSR polynomial and key level names.
package key_sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } key_state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic        KEY_PRESSED  = 1'b0;
    localparam logic        KEY_RELEASED = 1'b1;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high.
module lfsr16
    import key_sim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = step ? lfsr_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/key_bounce_gen.sv
// Bouncing active-low pushbutton source: one press/hold/release waveform per
// accepted start, with LFSR-timed contact bounce on both edges.
//
//   state   | meaning
//   IDLE    | waiting for start
//   PRESS   | press bounce burst, key ends low
//   HOLD    | key stable low for the latched hold time
//   RELEASE | release bounce burst, key ends high
//   DONE    | one-cycle done pulse
module key_bounce_gen
    import key_sim_pkg::*;
#(
    parameter int          BOUNCE_PAIRS = 4,
    parameter int          SEG_MIN      = 16,
    parameter int          SEG_BITS     = 6,
    parameter int          HOLD_W       = 24,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              busy,
    output logic              done,
    output logic              key_out
);

    localparam int SEG_W  = $clog2(SEG_MIN + (2 ** SEG_BITS));
    localparam int EDGE_W = $clog2(2 * BOUNCE_PAIRS + 2);
    localparam logic [SEG_W-1:0]  SEG_MIN_M1 = SEG_W'(SEG_MIN - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * BOUNCE_PAIRS);
    localparam key_state_t        AFTER_ACCEPT = (BOUNCE_PAIRS == 0) ? ST_HOLD : ST_PRESS;

    key_state_t        state_q, state_d;
    logic              key_q, key_d;
    logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              armed_q, armed_d;
    logic [15:0]       lfsr_q;
    logic              lfsr_step;

    logic              accept, seg_exp, hold_exp, rel_last;
    logic [EDGE_W-1:0] edge_inc;
    logic [SEG_W-1:0]  seg_load;
    logic              unused_lfsr_hi;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // armed_q blocks a start arriving on the first edge after reset release.
    assign accept   = (state_q == ST_IDLE) && start && armed_q;
    assign seg_exp  = (seg_cnt_q == '0);
    assign hold_exp = (hold_cnt_q == '0);
    assign edge_inc = edge_cnt_q + EDGE_W'(1);
    assign rel_last = (edge_cnt_q == EDGE_LAST);
    assign seg_load = SEG_MIN_M1 + SEG_W'(lfsr_q[SEG_BITS-1:0]);
    assign unused_lfsr_hi = ^lfsr_q[15:SEG_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= KEY_RELEASED;
            seg_cnt_q  <= '0;
            hold_cnt_q <= '0;
            edge_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            seg_cnt_q  <= seg_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept)                          state_d = AFTER_ACCEPT;
            ST_PRESS:   if (seg_exp && edge_inc == EDGE_LAST) state_d = ST_HOLD;
            ST_HOLD:    if (hold_exp)                        state_d = ST_RELEASE;
            ST_RELEASE: if (rel_last)                        state_d = ST_DONE;
            ST_DONE:                                         state_d = ST_IDLE;
            default:                                         state_d = ST_IDLE;
        endcase
    end

    // Every key edge reloads the segment timer and advances the LFSR once.
    always_comb begin
        key_d      = key_q;
        seg_cnt_d  = seg_cnt_q;
        hold_cnt_d = hold_cnt_q;
        edge_cnt_d = edge_cnt_q;
        armed_d    = 1'b1;
        lfsr_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    key_d      = KEY_PRESSED;
                    lfsr_step  = 1'b1;
                    seg_cnt_d  = seg_load;
                    edge_cnt_d = '0;
                    hold_cnt_d = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
                end
            end
            ST_PRESS: begin
                if (seg_exp) begin
                    key_d      = ~key_q;
                    lfsr_step  = 1'b1;
                    seg_cnt_d  = seg_load;
                    edge_cnt_d = edge_inc;
                end else begin
                    seg_cnt_d  = seg_cnt_q - SEG_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_exp) begin
                    key_d      = KEY_RELEASED;
                    lfsr_step  = 1'b1;
                    seg_cnt_d  = seg_load;
                    edge_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!rel_last) begin
                    if (seg_exp) begin
                        key_d      = ~key_q;
                        lfsr_step  = 1'b1;
                        seg_cnt_d  = seg_load;
                        edge_cnt_d = edge_inc;
                    end else begin
                        seg_cnt_d  = seg_cnt_q - SEG_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_PRESS) || (state_q == ST_HOLD) || (state_q == ST_RELEASE);
        done    = (state_q == ST_DONE);
        key_out = key_q;
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed + randomized bench for key_bounce_gen: clean-edge timing, bounce
// waveform against an arithmetic LFSR timing model, start filtering and reset.
module tb_key_bounce_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start4;
    logic [23:0] hold0, hold4;
    logic        busy0, done0, key0;
    logic        busy4, done4, key4;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_lfsr;

    always #5 clk = ~clk;

    key_bounce_gen #(.BOUNCE_PAIRS(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .hold_cycles(hold0),
        .busy(busy0), .done(done0), .key_out(key0)
    );

    key_bounce_gen dut4 (
        .clk(clk), .rst(rst), .start(start4), .hold_cycles(hold4),
        .busy(busy4), .done(done4), .key_out(key4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return (v >> 1) ^ ((v % 2 == 1) ? 16'hB400 : 16'h0000);
    endfunction

    // Toggle times (sample index after accept) follow from the LFSR state at
    // each edge: bounce gap = 16 + low 6 bits, the press->release gap = hold.
    task automatic wave4(input logic [23:0] h, input bit poke);
        int          t[18];
        int          obs[$];
        int          hh, done_k, done_cnt, done_at, busy_bad, bad_gaps, n, g;
        logic [15:0] l;
        logic        prev;
        hh = (h == 0) ? 1 : int'(h);
        l = ref_lfsr;
        t[0] = 1;
        for (int i = 0; i < 17; i++) begin
            g = (i == 8) ? hh : 16 + int'(l[5:0]);
            l = ref_step(l);
            t[i+1] = t[i] + g;
        end
        ref_lfsr = ref_step(l);
        done_k   = t[17] + 1;
        done_cnt = 0; done_at = -1; busy_bad = 0; bad_gaps = 0;
        prev = 1'b1;
        hold4 = h;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (key4 !== prev) obs.push_back(k);
            prev = key4;
            if (done4 === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (busy4 !== (k < done_k)) busy_bad++;
            if (k <= done_k) begin
                start4 = poke && ((k == t[8] + 3) || (k == done_k));
                hold4  = start4 ? 24'd5 : h;
                tick();
                start4 = 1'b0;
            end
        end
        chk("toggle_count", obs.size(), 18);
        n = (obs.size() < 18) ? obs.size() : 18;
        for (int i = 0; i < n; i++) chk($sformatf("toggle_time[%0d]", i), obs[i], t[i]);
        for (int i = 0; i + 1 < n; i++) begin
            if (i != 8 && (obs[i+1] - obs[i] < 16 || obs[i+1] - obs[i] > 79)) bad_gaps++;
        end
        chk("gap_range_violations", bad_gaps, 0);
        if (n > 9) chk("hold_low_time", obs[9] - obs[8], hh);
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_at, done_k);
        chk("busy_mismatch_cycles", busy_bad, 0);
        chk("key_idle_after", int'(key4), 1);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start4 = 1'b0;
        hold0 = '0; hold4 = '0;
        ref_lfsr = SEED;
        tick(); tick();
        chk("rst_key0", int'(key0), 1);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_key4", int'(key4), 1);
        chk("rst_busy4", int'(busy4), 0);
        rst = 1'b0;
        tick(); tick();

        // Clean edges, hold 10.
        hold0 = 24'd10;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            chk($sformatf("h10_key@%0d", k), int'(key0), (k <= 10) ? 0 : 1);
            chk($sformatf("h10_busy@%0d", k), int'(busy0), (k <= 11) ? 1 : 0);
            chk($sformatf("h10_done@%0d", k), int'(done0), (k == 12) ? 1 : 0);
            tick();
        end

        // hold_cycles = 0 behaves as 1.
        hold0 = 24'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("h0_key@%0d", k), int'(key0), (k == 1) ? 0 : 1);
            chk($sformatf("h0_busy@%0d", k), int'(busy0), (k <= 2) ? 1 : 0);
            chk($sformatf("h0_done@%0d", k), int'(done0), (k == 3) ? 1 : 0);
            tick();
        end

        // Bouncing waveforms; the middle one pokes start in HOLD and DONE,
        // and the last one is started in the cycle right after done.
        wave4(24'($urandom_range(20, 200)), 1'b0);
        wave4(24'($urandom_range(20, 200)), 1'b1);
        wave4(24'($urandom_range(20, 200)), 1'b0);

        // Reset in the middle of the press burst.
        hold4 = 24'd40;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        chk("pre_rst_busy", int'(busy4), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_key", int'(key4), 1);
        chk("async_rst_busy", int'(busy4), 0);
        chk("async_rst_done", int'(done4), 0);
        tick();
        chk("rst_hold_done", int'(done4), 0);
        tick();
        rst = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("start_at_rst_release_busy", int'(busy4), 0);
        chk("start_at_rst_release_key", int'(key4), 1);
        tick();
        chk("idle_after_release_done", int'(done4), 0);
        ref_lfsr = SEED;
        wave4(24'($urandom_range(20, 200)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
